arm_decode_frontend: RTL and testbench

Fetch/decode front end that produces the inputs the microsequencer consumes: one-hot instruction family, condition-pass, and the L/P/A bits.
- Runs a single-outstanding fetch handshake to instruction memory.
- Holds the instruction register (IR) and the NZCV flags register.
- Decodes IR combinationally from registered state.
- Sits between instruction memory, the ALU flag output and the control-store sequencer.

---
 rtl/arm_decode_pkg.sv | 71 +++++++
 rtl/arm_decode_frontend_cond.sv | 38 +++
 rtl/arm_decode_frontend.sv | 98 +++++++++
 tb/tb_arm_decode_frontend.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_decode_pkg.sv
// Shared constants for the ARM fetch/decode front end: family indices, condition
// codes, NZCV bit positions, fetch FSM encoding and the instruction family decoder.
package arm_decode_pkg;

  localparam int FAM_DP_REG  = 0;
  localparam int FAM_DP_IMM  = 1;
  localparam int FAM_MUL     = 2;
  localparam int FAM_MULL    = 3;
  localparam int FAM_SWP     = 4;
  localparam int FAM_HWORD   = 5;
  localparam int FAM_BX      = 6;
  localparam int FAM_PSR     = 7;
  localparam int FAM_LS_IMM  = 8;
  localparam int FAM_LS_REG  = 9;
  localparam int FAM_UNDEF   = 10;
  localparam int FAM_LDM_STM = 11;
  localparam int FAM_BRANCH  = 12;
  localparam int FAM_COPROC  = 13;
  localparam int FAM_SWI     = 14;
  localparam int FAM_RSVD    = 15;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

  // Ordered first-match decode; the specific encodings hide inside the generic ones below them.
  function automatic logic [3:0] decode_family(input logic [31:0] ir);
    logic [3:0] fam;
    if (ir[27:4] == 24'h12FFF1)                                          fam = 4'(FAM_BX);
    else if (ir[27:22] == 6'b000000 && ir[7:4] == 4'b1001)               fam = 4'(FAM_MUL);
    else if (ir[27:23] == 5'b00001 && ir[7:4] == 4'b1001)                fam = 4'(FAM_MULL);
    else if (ir[27:23] == 5'b00010 && ir[21:20] == 2'b00 && ir[11:4] == 8'b00001001)
                                                                         fam = 4'(FAM_SWP);
    else if (ir[27:25] == 3'b000 && ir[7] && ir[4] && ir[6:5] != 2'b00)  fam = 4'(FAM_HWORD);
    else if (ir[27:26] == 2'b00 && ir[24:23] == 2'b10 && !ir[20])        fam = 4'(FAM_PSR);
    else if (ir[27:25] == 3'b000)                                        fam = 4'(FAM_DP_REG);
    else if (ir[27:25] == 3'b001)                                        fam = 4'(FAM_DP_IMM);
    else if (ir[27:25] == 3'b010)                                        fam = 4'(FAM_LS_IMM);
    else if (ir[27:25] == 3'b011 && ir[4])                               fam = 4'(FAM_UNDEF);
    else if (ir[27:25] == 3'b011)                                        fam = 4'(FAM_LS_REG);
    else if (ir[27:25] == 3'b100)                                        fam = 4'(FAM_LDM_STM);
    else if (ir[27:25] == 3'b101)                                        fam = 4'(FAM_BRANCH);
    else if (ir[27:24] == 4'b1111)                                       fam = 4'(FAM_SWI);
    else                                                                 fam = 4'(FAM_COPROC);
    return fam;
  endfunction

endpackage

// File: rtl/arm_decode_frontend_cond.sv
// ARMv4 condition evaluator: purely combinational (cond, nzcv) -> pass.
module arm_cond_eval
  import arm_decode_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_decode_frontend.sv
// Fetch/decode front end: single-outstanding fetch FSM, IR and NZCV registers, family/COND decode.
// Optional build macro COND_BYPASS_EN: COND sees alu_nzcv while ld_cc is asserted.
module arm_decode_frontend
  import arm_decode_pkg::*;
#(
  parameter logic [3:0]  RESET_FLAGS = 4'b0000,
  parameter logic [31:0] RESET_IR    = 32'hE1A00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        ld_cc,
  input  logic [3:0]  alu_nzcv,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [3:0]  flags,
  output logic [15:0] family_bits,
  output logic        COND,
  output logic        L,
  output logic        P,
  output logic        A
);

  fetch_state_e state_q;
  logic         mem_req_q;
  logic         ir_valid_q;
  logic [31:0]  ir_q;
  logic [3:0]   flags_q;
  logic [3:0]   fam_idx;
  logic [3:0]   cond_nzcv;

  // mem_ack outside WAIT is dropped, so a response arriving after reset cannot touch IR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      ir_valid_q <= 1'b0;
      ir_q       <= RESET_IR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch_start) begin
            state_q    <= ST_WAIT;
            mem_req_q  <= 1'b1;
            ir_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            ir_q       <= mem_rdata;
            ir_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= RESET_FLAGS;
    end else if (ld_cc) begin
      flags_q <= alu_nzcv;
    end
  end

`ifdef COND_BYPASS_EN
  assign cond_nzcv = ld_cc ? alu_nzcv : flags_q;
`else
  assign cond_nzcv = flags_q;
`endif

  arm_cond_eval u_cond (
    .cond (ir_q[31:28]),
    .nzcv (cond_nzcv),
    .pass (COND)
  );

  assign fam_idx     = decode_family(ir_q);
  assign family_bits = 16'h0001 << fam_idx;

  assign mem_req  = mem_req_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign flags    = flags_q;
  assign L        = ir_q[20];
  assign P        = ir_q[24];
  assign A        = ir_q[21];

endmodule

// File: tb/tb_arm_decode_frontend.sv
// Directed, table-driven bench for arm_decode_frontend plus hand-written fetch/reset sequences.
module tb_arm_decode_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ld_cc;
  logic [3:0]  alu_nzcv;
  logic [31:0] ir;
  logic        ir_valid;
  logic [3:0]  flags;
  logic [15:0] family_bits;
  logic        COND, L, P, A;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] RST_IR = 32'hE1A00000;

  arm_decode_frontend dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ld_cc       (ld_cc),
    .alu_nzcv    (alu_nzcv),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .flags       (flags),
    .family_bits (family_bits),
    .COND        (COND),
    .L           (L),
    .P           (P),
    .A           (A)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  nzcv;
    logic [15:0] fam;
    logic        cond;
    logic [2:0]  lpa;
  } vec_t;

  vec_t vecs[23];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Minimum-latency fetch: fetch_start for one cycle, mem_ack in the next.
  task automatic do_fetch(input logic [31:0] instr);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    mem_ack     = 1'b1;
    mem_rdata   = instr;
    tick();
    mem_ack     = 1'b0;
  endtask

  task automatic load_flags(input logic [3:0] nzcv);
    ld_cc    = 1'b1;
    alu_nzcv = nzcv;
    tick();
    ld_cc    = 1'b0;
  endtask

  initial begin
    logic exp_bypass;
    vecs[0]  = '{32'hE3A01005, 4'b0000, 16'h0002, 1'b1, 3'b011};
    vecs[1]  = '{32'h0A000002, 4'b0000, 16'h1000, 1'b0, 3'b000};
    vecs[2]  = '{32'h0A000002, 4'b0100, 16'h1000, 1'b1, 3'b000};
    vecs[3]  = '{32'hE5912004, 4'b0000, 16'h0100, 1'b1, 3'b110};
    vecs[4]  = '{32'hE0214392, 4'b0000, 16'h0004, 1'b1, 3'b001};
    vecs[5]  = '{32'hE0010392, 4'b0000, 16'h0004, 1'b1, 3'b000};
    vecs[6]  = '{32'hE12FFF11, 4'b0000, 16'h0040, 1'b1, 3'b011};
    vecs[7]  = '{32'hE1D120B2, 4'b0000, 16'h0020, 1'b1, 3'b110};
    vecs[8]  = '{32'hEF000000, 4'b0000, 16'h4000, 1'b1, 3'b010};
    vecs[9]  = '{32'hF5912004, 4'b0000, 16'h0100, 1'b0, 3'b110};
    vecs[10] = '{32'h8A000000, 4'b0010, 16'h1000, 1'b1, 3'b000};
    vecs[11] = '{32'h8A000000, 4'b0110, 16'h1000, 1'b0, 3'b000};
    vecs[12] = '{32'hBA000000, 4'b1000, 16'h1000, 1'b1, 3'b000};
    vecs[13] = '{32'hDA000000, 4'b0001, 16'h1000, 1'b1, 3'b000};
    vecs[14] = '{32'hCA000000, 4'b1001, 16'h1000, 1'b1, 3'b000};
    vecs[15] = '{32'hE7912004, 4'b0000, 16'h0200, 1'b1, 3'b110};
    vecs[16] = '{32'hE7F000F0, 4'b0000, 16'h0400, 1'b1, 3'b111};
    vecs[17] = '{32'hE8BD0003, 4'b0000, 16'h0800, 1'b1, 3'b101};
    vecs[18] = '{32'hE10F0000, 4'b0000, 16'h0080, 1'b1, 3'b010};
    vecs[19] = '{32'hE1020091, 4'b0000, 16'h0010, 1'b1, 3'b010};
    vecs[20] = '{32'hE0810392, 4'b0000, 16'h0008, 1'b1, 3'b000};
    vecs[21] = '{32'hEE000010, 4'b0000, 16'h2000, 1'b1, 3'b000};
    vecs[22] = '{32'h1A000000, 4'b0100, 16'h1000, 1'b0, 3'b000};

    rst = 1'b0; fetch_start = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    ld_cc = 1'b0; alu_nzcv = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req",  32'(mem_req), 32'd0);
    chk("rst_ir",       ir, RST_IR);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_flags",    32'(flags), 32'd0);
    chk("rst_family",   32'(family_bits), 32'h0001);
    chk("rst_cond",     32'(COND), 32'd1);
    $display("reset: ir=%h family=%h cond=%0d", ir, family_bits, COND);
    rst = 1'b1;
    tick();

    // Fetch with mem_ack three cycles after fetch_start, plus a stray fetch_start in WAIT.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("fetch_ir_valid_clr", 32'(ir_valid), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      chk("fetch_mem_req_wait", 32'(mem_req), 32'd1);
      if (c == 2) fetch_start = 1'b1;
      if (c == 3) begin
        fetch_start = 1'b0;
        mem_ack     = 1'b1;
        mem_rdata   = 32'hE3A01005;
      end
      tick();
    end
    mem_ack = 1'b0;
    chk("fetch_mem_req_done", 32'(mem_req), 32'd0);
    chk("fetch_ir",           ir, 32'hE3A01005);
    chk("fetch_ir_valid",     32'(ir_valid), 32'd1);
    chk("fetch_family",       32'(family_bits), 32'h0002);
    chk("fetch_cond",         32'(COND), 32'd1);
    tick();
    chk("no_extra_fetch",     32'(mem_req), 32'd0);
    $display("fetch: ir=%h valid=%0d family=%h", ir, ir_valid, family_bits);

    // mem_ack while IDLE must not load IR.
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_ir", ir, 32'hE3A01005);
    chk("idle_ack_req", 32'(mem_req), 32'd0);
    $display("idle ack: ir=%h", ir);

    foreach (vecs[i]) begin
      load_flags(vecs[i].nzcv);
      do_fetch(vecs[i].instr);
      chk("vec_ir_valid", 32'(ir_valid), 32'd1);
      chk("vec_family",   32'(family_bits), 32'(vecs[i].fam));
      chk("vec_cond",     32'(COND), 32'(vecs[i].cond));
      chk("vec_lpa",      32'({L, P, A}), 32'(vecs[i].lpa));
      $display("vec %0d: ir=%h nzcv=%b family=%h cond=%0d lpa=%b",
               i, ir, flags, family_bits, COND, {L, P, A});
    end

    // ld_cc in the same cycle COND is observed.
`ifdef COND_BYPASS_EN
    exp_bypass = 1'b1;
`else
    exp_bypass = 1'b0;
`endif
    load_flags(4'b0000);
    do_fetch(32'h0A000002);
    chk("same_cyc_pre", 32'(COND), 32'd0);
    ld_cc = 1'b1; alu_nzcv = 4'b0100;
    #1;
    chk("same_cyc_cond", 32'(COND), 32'(exp_bypass));
    tick();
    ld_cc = 1'b0;
    chk("same_cyc_flags", 32'(flags), 32'b0100);
    chk("same_cyc_after", 32'(COND), 32'd1);
    $display("same-cycle ld_cc: flags=%b cond=%0d", flags, COND);

    // Asynchronous reset while waiting for memory, then a late mem_ack.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("midrst_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_req_async", 32'(mem_req), 32'd0);
    chk("midrst_ir",        ir, RST_IR);
    chk("midrst_ir_valid",  32'(ir_valid), 32'd0);
    chk("midrst_flags",     32'(flags), 32'd0);
    tick();
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hE3A01005;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_ir",       ir, RST_IR);
    chk("late_ack_ir_valid", 32'(ir_valid), 32'd0);
    chk("late_ack_req",      32'(mem_req), 32'd0);
    chk("late_ack_family",   32'(family_bits), 32'h0001);
    $display("reset mid-fetch: ir=%h valid=%0d req=%0d", ir, ir_valid, mem_req);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
